disp_bcd_formatter: RTL

- Formats a 32-bit value into eight 6-bit digit codes that feed the time-multiplexed seven-segment display stage (in0..in7).
- Two modes: decimal (iterative binary-to-BCD, leading-zero blanking) and raw hex.
- Also handles decimal-point placement and overflow indication.
- Outputs are registered and held between updates, so the display never flickers during conversion.

---
 rtl/disp_bcd_formatter_pkg.sv | 39 +++
 rtl/disp_bcd_formatter_bin2bcd_seq.sv | 51 +++++
 rtl/disp_bcd_formatter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/disp_bcd_formatter_pkg.sv
// Shared definitions for the BCD display formatter.
// Covers digit-code field positions, the decimal limit and the FSM states.
package disp_bcd_formatter_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 6;

    localparam int unsigned EN_BIT  = 5;
    localparam int unsigned NIB_MSB = 4;
    localparam int unsigned NIB_LSB = 1;
    localparam int unsigned DP_BIT  = 0;

    localparam logic [31:0] MAX_DEC = 32'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_FORMAT
    } state_t;

    function automatic logic [DIGIT_W-1:0] make_digit(
        input logic       lit,
        input logic [3:0] nib,
        input logic       point,
        input bit         dp_active_low
    );
        logic [DIGIT_W-1:0] d;
        d                   = '0;
        d[EN_BIT]           = lit;
        d[NIB_MSB:NIB_LSB]  = nib;
        d[DP_BIT]           = point ^ dp_active_low;
        return d;
    endfunction

    function automatic logic [DIGIT_W-1:0] blank_digit(input bit dp_active_low);
        return make_digit(1'b0, 4'd0, 1'b0, dp_active_low);
    endfunction

endpackage

// File: rtl/disp_bcd_formatter_bin2bcd_seq.sv
// Iterative 32-bit double-dabble converter, one iteration per clock.
// done is high during the final iteration; bcd is complete after that edge.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        done,
    output logic [31:0] bcd
);

    logic [31:0] shift_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic [31:0] adj;
    logic [63:0] nxt;

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        nxt = {adj, shift_q} << 1;
    end

    assign done = busy_q && (cnt_q == 5'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            bcd     <= '0;
        end else if (start) begin
            shift_q <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            bcd     <= '0;
        end else if (busy_q) begin
            bcd     <= nxt[63:32];
            shift_q <= nxt[31:0];
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/disp_bcd_formatter.sv
// Formats a 32-bit value into eight registered seven-segment digit codes,
// decimal (with leading-zero blanking and overflow) or raw hex.
module disp_bcd_formatter
    import disp_bcd_formatter_pkg::*;
#(
    parameter bit LZ_BLANK      = 1'b1,
    parameter bit DP_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        hex_mode,
    input  logic        dp_en,
    input  logic [2:0]  dp_pos,
    output logic        ready,
    output logic        done,
    output logic        overflow,
    output logic [5:0]  out0,
    output logic [5:0]  out1,
    output logic [5:0]  out2,
    output logic [5:0]  out3,
    output logic [5:0]  out4,
    output logic [5:0]  out5,
    output logic [5:0]  out6,
    output logic [5:0]  out7
);

    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = blank_digit(DP_ACTIVE_LOW);

    state_t state_q, state_d;

    logic [31:0] value_q;
    logic        hex_q;
    logic        dp_en_q;
    logic [2:0]  dp_pos_q;
    logic        err_q;

    logic        accept;
    logic        dec_over;
    logic        conv_start;
    logic        conv_done;
    logic [31:0] bcd;

    logic [DIGIT_W-1:0] digit_d [NUM_DIGITS];
    logic [DIGIT_W-1:0] digit_q [NUM_DIGITS];
    logic               overflow_q;
    logic               done_q;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (hex_mode || dec_over) ? ST_FORMAT : ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready      = (state_q == ST_IDLE);
        accept     = start && ready;
        dec_over   = !hex_mode && (value > MAX_DEC);
        conv_start = accept && !hex_mode && !dec_over;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q  <= '0;
            hex_q    <= 1'b0;
            dp_en_q  <= 1'b0;
            dp_pos_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            value_q  <= value;
            hex_q    <= hex_mode;
            dp_en_q  <= dp_en;
            dp_pos_q <= dp_pos;
            err_q    <= dec_over;
        end
    end

    // Scan from the most significant digit so nz_seen means "some digit m >= n is nonzero".
    always_comb begin : format_digits
        logic        nz_seen;
        logic        lit;
        logic        point;
        logic [3:0]  nib;
        int unsigned n;
        digit_d = '{default: BLANK_DIGIT};
        nz_seen = 1'b0;
        lit     = 1'b0;
        point   = 1'b0;
        nib     = '0;
        n       = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            n       = NUM_DIGITS - 1 - i;
            nib     = hex_q ? value_q[4*n +: 4] : bcd[4*n +: 4];
            nz_seen = nz_seen || (nib != 4'd0);
            point   = dp_en_q && (dp_pos_q == 3'(n));
            lit     = hex_q || !LZ_BLANK || nz_seen || (n == 0)
                      || (dp_en_q && (dp_pos_q >= 3'(n)));
            if (err_q) begin
                lit   = 1'b1;
                nib   = 4'hF;
                point = 1'b0;
            end
            if (!lit) begin
                nib = '0;
            end
            digit_d[n] = make_digit(lit, nib, point, DP_ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q    <= '{default: BLANK_DIGIT};
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FORMAT);
            if (state_q == ST_FORMAT) begin
                digit_q    <= digit_d;
                overflow_q <= err_q;
            end
        end
    end

    assign done     = done_q;
    assign overflow = overflow_q;
    assign out0     = digit_q[0];
    assign out1     = digit_q[1];
    assign out2     = digit_q[2];
    assign out3     = digit_q[3];
    assign out4     = digit_q[4];
    assign out5     = digit_q[5];
    assign out6     = digit_q[6];
    assign out7     = digit_q[7];

endmodule
